// File: rtl/mem_stage.sv
// mem_stage: data memory and stack pointer of the 16-bit pipeline.
// Multi-cycle load/store/push/pop; stalls upstream while busy.
module mem_stage #(
  parameter int ADDR_W  = 11,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MR,
  input  logic              MW,
  input  logic              pushEn,
  input  logic              popEn,
  input  logic [15:0]       addr,
  input  logic [15:0]       writeData,
  output logic [15:0]       memData,
  output logic              memValid,
  output logic              stall,
  output logic [ADDR_W-1:0] spOut
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_ST,
    OP_LD
  } op_t;

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] ea;
  logic [15:0]       mem [2**ADDR_W];
  op_t               op;
  logic              req;
  logic              done;
  logic              busy;
  logic              fire;
  logic              we;
  logic              unused_addr;

  assign unused_addr = ^addr[15:ADDR_W];

  assign req = MR | MW | pushEn | popEn;

  always_comb begin
    op = OP_NONE;
    unique case (1'b1)
      pushEn:                    op = OP_PUSH;
      !pushEn && popEn:          op = OP_POP;
      !pushEn && !popEn && MW:   op = OP_ST;
      !pushEn && !popEn && !MW
        && MR:                   op = OP_LD;
      default:                   op = OP_NONE;
    endcase
  end

  always_comb begin
    ea = addr[ADDR_W-1:0];
    unique case (op)
      OP_PUSH: ea = sp;
      OP_POP:  ea = sp + ADDR_W'(1);
      default: ea = addr[ADDR_W-1:0];
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done    = 1'b0;
    busy    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            done = 1'b1;
          end else begin
            busy    = 1'b1;
            state_n = BUSY;
            cnt_n   = ONE;
          end
        end
      end
      BUSY: begin
        if (cnt == LAST) begin
          done    = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          busy  = 1'b1;
          cnt_n = cnt + ONE;
        end
      end
    endcase
  end

  // Gating with rst keeps reset effective on the outputs
  // and blocks any write while it is held low.
  assign fire     = done & rst;
  assign stall    = busy & rst;
  assign memValid = fire & ((op == OP_LD) | (op == OP_POP));
  assign we       = fire & ((op == OP_ST) | (op == OP_PUSH));
  assign memData  = mem[ea];
  assign spOut    = sp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      sp    <= '1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (fire && op == OP_PUSH) begin
        sp <= sp - ADDR_W'(1);
      end else if (fire && op == OP_POP) begin
        sp <= sp + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[ea] <= writeData;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage at LATENCY 1, 2, 3.
// Instance k runs with LATENCY k+1.
module tb_mem_stage;

  logic        clk;
  logic        rstv [3];
  logic        mr   [3];
  logic        mw   [3];
  logic        pu   [3];
  logic        po   [3];
  logic [15:0] ad   [3];
  logic [15:0] wd   [3];
  logic [15:0] md   [3];
  logic        mv   [3];
  logic        st   [3];
  logic [10:0] sp   [3];

  int checks;
  int fails;
  int cyc;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage #(
      .ADDR_W (11),
      .LATENCY(g + 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rstv[g]),
      .MR       (mr[g]),
      .MW       (mw[g]),
      .pushEn   (pu[g]),
      .popEn    (po[g]),
      .addr     (ad[g]),
      .writeData(wd[g]),
      .memData  (md[g]),
      .memValid (mv[g]),
      .stall    (st[g]),
      .spOut    (sp[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic clr(input int k);
    pu[k] = 1'b0;
    po[k] = 1'b0;
    mw[k] = 1'b0;
    mr[k] = 1'b0;
    ad[k] = 16'h0;
    wd[k] = 16'h0;
  endtask

  // Apply one request, wait out the stall (bounded), capture the
  // completion-cycle outputs, then clock the completion edge.
  task automatic do_op(input int k, input logic p_u, p_o, w, r,
                       input logic [15:0] a, d,
                       output int stalls,
                       output logic [15:0] data,
                       output logic valid);
    pu[k] = p_u;
    po[k] = p_o;
    mw[k] = w;
    mr[k] = r;
    ad[k] = a;
    wd[k] = d;
    #1;
    stalls = 0;
    while (st[k] === 1'b1 && stalls < 20) begin
      @(posedge clk);
      #1;
      stalls++;
    end
    data  = md[k];
    valid = mv[k];
    @(posedge clk);
    #1;
    clr(k);
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      rstv[k] = 1'b1;
      clr(k);
    end
    #1;
    for (int k = 0; k < 3; k++) rstv[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rstv[k] = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sp[k] !== 11'h7FF) begin
        fails++;
        $display("FAIL reset_sp[%0d] got=%h exp=7ff", k, sp[k]);
      end
      checks++;
      if (st[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_stall[%0d] got=%b exp=0", k, st[k]);
      end
      checks++;
      if (mv[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_valid[%0d] got=%b exp=0", k, mv[k]);
      end
    end
  endtask

  task automatic test_idle;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (st[1] !== 1'b0 || mv[1] !== 1'b0 || sp[1] !== 11'h7FF) begin
        fails++;
        $display("FAIL idle got stall=%b valid=%b sp=%h exp 0 0 7ff",
                 st[1], mv[1], sp[1]);
      end
    end
  endtask

  task automatic test_store_load;
    int n;
    logic [15:0] d;
    logic v;
    do_op(1, 0, 0, 1, 0, 16'h0010, 16'hBEEF, n, d, v);
    checks++;
    if (n !== 1 || v !== 1'b0) begin
      fails++;
      $display("FAIL store_l2 got stalls=%0d valid=%b exp 1 0", n, v);
    end
    do_op(1, 0, 0, 0, 1, 16'h0010, 16'h0000, n, d, v);
    checks++;
    if (n !== 1) begin
      fails++;
      $display("FAIL load_stalls got=%0d exp=1", n);
    end
    checks++;
    if (d !== 16'hBEEF || v !== 1'b1) begin
      fails++;
      $display("FAIL load_data got=%h/%b exp=beef/1", d, v);
    end
  endtask

  task automatic test_push_pop;
    int n;
    logic [15:0] d;
    logic v;
    do_op(1, 1, 0, 0, 0, 16'h0, 16'h1234, n, d, v);
    checks++;
    if (sp[1] !== 11'h7FE || n !== 1) begin
      fails++;
      $display("FAIL push1 got sp=%h stalls=%0d exp 7fe 1", sp[1], n);
    end
    do_op(1, 1, 0, 0, 0, 16'h0, 16'h5678, n, d, v);
    checks++;
    if (sp[1] !== 11'h7FD) begin
      fails++;
      $display("FAIL push2 got sp=%h exp=7fd", sp[1]);
    end
    do_op(1, 0, 1, 0, 0, 16'h0, 16'h0, n, d, v);
    checks++;
    if (d !== 16'h5678 || v !== 1'b1 || sp[1] !== 11'h7FE) begin
      fails++;
      $display("FAIL pop1 got d=%h v=%b sp=%h exp 5678 1 7fe",
               d, v, sp[1]);
    end
    do_op(1, 0, 1, 0, 0, 16'h0, 16'h0, n, d, v);
    checks++;
    if (d !== 16'h1234 || v !== 1'b1 || sp[1] !== 11'h7FF) begin
      fails++;
      $display("FAIL pop2 got d=%h v=%b sp=%h exp 1234 1 7ff",
               d, v, sp[1]);
    end
  endtask

  task automatic test_priority;
    int n;
    logic [15:0] d;
    logic v;
    do_op(1, 0, 0, 1, 0, 16'h0020, 16'h0F0F, n, d, v);
    do_op(1, 1, 0, 1, 0, 16'h0020, 16'hAAAA, n, d, v);
    checks++;
    if (sp[1] !== 11'h7FE) begin
      fails++;
      $display("FAIL prio_sp got=%h exp=7fe", sp[1]);
    end
    do_op(1, 0, 0, 0, 1, 16'h0020, 16'h0, n, d, v);
    checks++;
    if (d !== 16'h0F0F) begin
      fails++;
      $display("FAIL prio_mw_blocked got=%h exp=0f0f", d);
    end
    do_op(1, 0, 1, 1, 1, 16'h0020, 16'h0, n, d, v);
    checks++;
    if (d !== 16'hAAAA || sp[1] !== 11'h7FF) begin
      fails++;
      $display("FAIL prio_pop got d=%h sp=%h exp aaaa 7ff", d, sp[1]);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [15:0] d;
    logic v;
    do_op(2, 0, 0, 1, 0, 16'h0030, 16'h2222, n, d, v);
    checks++;
    if (n !== 2) begin
      fails++;
      $display("FAIL store_l3_stalls got=%0d exp=2", n);
    end
    mw[2] = 1'b1;
    ad[2] = 16'h0030;
    wd[2] = 16'h1111;
    #1;
    checks++;
    if (st[2] !== 1'b1) begin
      fails++;
      $display("FAIL mid_stall1 got=%b exp=1", st[2]);
    end
    @(posedge clk);
    #1;
    rstv[2] = 1'b0;
    #1;
    checks++;
    if (st[2] !== 1'b0) begin
      fails++;
      $display("FAIL mid_async_stall got=%b exp=0", st[2]);
    end
    repeat (2) @(posedge clk);
    #1;
    clr(2);
    rstv[2] = 1'b1;
    @(posedge clk);
    #1;
    do_op(2, 0, 0, 0, 1, 16'h0030, 16'h0, n, d, v);
    checks++;
    if (d !== 16'h2222 || v !== 1'b1 || n !== 2) begin
      fails++;
      $display("FAIL mid_no_write got d=%h v=%b n=%0d exp 2222 1 2",
               d, v, n);
    end
  endtask

  task automatic test_wrap;
    int n;
    logic [15:0] d;
    logic v;
    do_op(0, 0, 0, 1, 0, 16'h0000, 16'hC0DE, n, d, v);
    checks++;
    if (n !== 0) begin
      fails++;
      $display("FAIL l1_store_stalls got=%0d exp=0", n);
    end
    do_op(0, 0, 1, 0, 0, 16'h0, 16'h0, n, d, v);
    checks++;
    if (d !== 16'hC0DE || v !== 1'b1 || sp[0] !== 11'h000 || n !== 0) begin
      fails++;
      $display("FAIL wrap_pop got d=%h v=%b sp=%h n=%0d exp c0de 1 000 0",
               d, v, sp[0], n);
    end
    do_op(0, 1, 0, 0, 0, 16'h0, 16'h5555, n, d, v);
    checks++;
    if (sp[0] !== 11'h7FF || n !== 0) begin
      fails++;
      $display("FAIL wrap_push got sp=%h n=%0d exp 7ff 0", sp[0], n);
    end
    do_op(0, 0, 1, 0, 0, 16'h0, 16'h0, n, d, v);
    checks++;
    if (d !== 16'h5555 || sp[0] !== 11'h000) begin
      fails++;
      $display("FAIL wrap_repop got d=%h sp=%h exp 5555 000", d, sp[0]);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int c0;
    logic [15:0] d;
    logic v;
    c0 = cyc;
    do_op(1, 0, 0, 1, 0, 16'h0040, 16'h1357, n, d, v);
    do_op(1, 0, 0, 0, 1, 16'h0040, 16'h0, n, d, v);
    checks++;
    if (d !== 16'h1357 || v !== 1'b1) begin
      fails++;
      $display("FAIL b2b_raw got d=%h v=%b exp 1357 1", d, v);
    end
    checks++;
    if (cyc - c0 !== 4) begin
      fails++;
      $display("FAIL b2b_cycles got=%0d exp=4", cyc - c0);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_idle();
    test_store_load();
    test_push_pop();
    test_priority();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 16-bit five-stage pipeline, between the E/M pipeline buffer (upstream) and the M/W buffer (downstream).
- Owns the data memory and the stack pointer.
- Executes load, store, push and pop with a configurable multi-cycle access latency.
- Stalls the upstream pipeline while an access is in flight, and presents read data to the M/W buffer on the completion cycle.

Parameters:
- ADDR_W, 11, data-memory address width; depth = 2^ADDR_W words of 16 bits.
- LATENCY, 2, cycles per memory operation (LATENCY >= 1).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- MR  input  1  memory read (load) request.
- MW  input  1  memory write (store) request.
- pushEn  input  1  stack push request.
- popEn  input  1  stack pop request.
- addr  input  16  load/store address; low ADDR_W bits used.
- writeData  input  16  store or push data.
- memData  output  16  read data for the M/W buffer.
- memValid  output  1  high in the completion cycle of MR or pop.
- stall  output  1  freezes PC and the F/D, D/E and E/M buffers.
- spOut  output  ADDR_W  current stack pointer.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-low.
- Reset state:
  - FSM goes to IDLE, cnt=0, SP=2^ADDR_W-1 (0x7FF at default width).
  - stall=0, memValid=0.
  - Memory array is not reset.
  - Applies immediately on rst low, including mid-operation: the in-flight op is abandoned and no write occurs.
- req = MR|MW|pushEn|popEn. Priority when several are high: pushEn > popEn > MW > MR. Only the winner executes.
- Effective address ea:
  - push: SP.
  - pop: SP+1, mod 2^ADDR_W.
  - MR/MW: addr[ADDR_W-1:0].
- FSM states IDLE, BUSY; counter cnt, width sufficient for LATENCY-1.
- IDLE with req:
  - LATENCY==1: this is the completion cycle, stall=0.
  - LATENCY>1: stall=1; next edge goes to BUSY with cnt=1.
- BUSY:
  - stall = (cnt != LATENCY-1).
  - cnt increments each edge.
  - When cnt==LATENCY-1, this is the completion cycle; the next edge returns to IDLE.
- Completion cycle (stall=0):
  - The upstream buffer advances at the same edge.
  - MW or push writes mem[ea] <= writeData at that edge.
  - push: SP <= SP-1 at that edge.
  - pop: SP <= SP+1 at that edge.
  - memValid=1 for MR and pop.
- Request inputs are held stable by upstream while stall=1. They are sampled only for priority decode and ea in each cycle.
- memData is a combinational read of mem[ea]:
  - Meaningful only when memValid=1; the M/W buffer captures it at the completion edge.
  - Otherwise memData reflects mem[ea] of the current inputs and is don't-care.
- Boundary conditions:
  - SP wraps modulo 2^ADDR_W: push at SP=0 gives SP=max; pop at SP=max reads mem[0] and sets SP=0. No overflow flag.
  - Back-to-back requests: a new req present in IDLE immediately after completion starts a new op with no idle bubble.
  - No req in IDLE: stall=0, memValid=0, no state change.
  - Read-after-write to the same ea in consecutive ops returns the new data.

Test Plan:
1. Reset values: hold rst=0, then release → spOut=0x7FF, stall=0, memValid=0.
2. Store then load, LATENCY=2:
   - MW=1, addr=0x0010, writeData=0xBEEF → stall=1 for one cycle, then 0.
   - Next op MR=1, addr=0x0010 → stall=1 for one cycle; completion cycle memData=0xBEEF, memValid=1.
3. Push/pop:
   - push 0x1234, then push 0x5678 → SP 0x7FF→0x7FE→0x7FD.
   - pop → memData=0x5678, SP=0x7FE.
   - pop → memData=0x1234, SP=0x7FF.
4. Priority: pushEn=1 and MW=1 with addr=0x0020, writeData=0xAAAA → mem[0x7FF]=0xAAAA, mem[0x020] unchanged, SP=0x7FE.
5. Reset mid-op: LATENCY=3, MW to addr 0x30 data 0x1111, assert rst in cycle 2 → stall drops asynchronously, FSM in IDLE, mem[0x30] retains its old value.
6. Wrap and LATENCY=1:
   - Pop with SP=0x7FF → reads mem[0x000], SP=0x000, stall never asserted.
   - Push at SP=0x000 → SP=0x7FF.
